shift_sub_divider: RTL



---
 rtl/shift_sub_divider.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/shift_sub_divider.sv
// rtl/shift_sub_divider.sv - sequential 8-bit restoring divider, one quotient bit per clock
// Define DIVIDER_SIGNED_EN for two's-complement operands with an extra FIXUP cycle.
module shift_sub_divider (
  input  logic       CLk,
  input  logic       Reset,
  input  logic [7:0] Din,
  input  logic       Load_Divisor,
  input  logic       Run,
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
  output logic [7:0] Divisor,
  output logic       Busy,
  output logic       Done,
  output logic       Div0
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ITER  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [8:0] a_reg;
  logic [7:0] q_reg;
  logic [7:0] s_reg;
  logic [2:0] cnt;
  logic       div0_reg;

  logic [7:0] s_mag;
  logic [7:0] din_mag;
  logic [9:0] a_shift;
  logic [9:0] diff;
  logic       borrow;

`ifdef DIVIDER_SIGNED_EN
  logic dvd_neg;
  logic sign_diff;

  // Plain 8-bit negation maps -128 onto 0x80, i.e. unsigned 128.
  assign s_mag   = s_reg[7] ? (8'd0 - s_reg) : s_reg;
  assign din_mag = Din[7]   ? (8'd0 - Din)   : Din;
`else
  assign s_mag   = s_reg;
  assign din_mag = Din;
`endif

  // A never exceeds 9 bits, so the 10-bit difference's top bit is the borrow.
  assign a_shift = {a_reg, q_reg[7]};
  assign diff    = a_shift - {2'b00, s_mag};
  assign borrow  = diff[9];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!Load_Divisor && Run) state_nxt = ITER;
      end
      ITER: begin
        if (cnt == 3'd7) begin
`ifdef DIVIDER_SIGNED_EN
          state_nxt = FIXUP;
`else
          state_nxt = DONE;
`endif
        end
      end
      FIXUP: state_nxt = DONE;
      DONE: begin
        if (!Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLk) begin
    if (Reset) begin
      state    <= IDLE;
      a_reg    <= 9'd0;
      q_reg    <= 8'd0;
      s_reg    <= 8'd0;
      cnt      <= 3'd0;
      div0_reg <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      dvd_neg   <= 1'b0;
      sign_diff <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (Load_Divisor) begin
            s_reg <= Din;
          end else if (Run) begin
            q_reg    <= din_mag;
            a_reg    <= 9'd0;
            cnt      <= 3'd0;
            div0_reg <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            dvd_neg   <= Din[7];
            sign_diff <= Din[7] ^ s_reg[7];
`endif
          end
        end
        ITER: begin
          cnt <= cnt + 3'd1;
          if (!borrow) begin
            a_reg <= diff[8:0];
            q_reg <= {q_reg[6:0], 1'b1};
          end else begin
            a_reg <= a_shift[8:0];
            q_reg <= {q_reg[6:0], 1'b0};
          end
`ifndef DIVIDER_SIGNED_EN
          if (cnt == 3'd7) div0_reg <= (s_reg == 8'd0);
`endif
        end
`ifdef DIVIDER_SIGNED_EN
        FIXUP: begin
          // With S=0 the quotient stays 0xFF; negating |dividend| restores raw Din.
          if ((s_reg != 8'd0) && sign_diff) q_reg <= 8'd0 - q_reg;
          if (dvd_neg) a_reg <= {1'b0, 8'd0 - a_reg[7:0]};
          div0_reg <= (s_reg == 8'd0);
        end
`endif
        DONE: begin
          if (Load_Divisor) s_reg <= Din;
        end
        default: begin
        end
      endcase
    end
  end

  assign Quotient  = q_reg;
  assign Remainder = a_reg[7:0];
  assign Divisor   = s_reg;
  assign Busy      = (state == ITER) || (state == FIXUP);
  assign Done      = (state == DONE);
  assign Div0      = div0_reg;

endmodule
